// File: rtl/softstart_seq_ctrl.sv
// Soft-start sequencer for the 5V step-down converter.
// Ramps the soft-start DAC code and gates driver enable / discharge.
module softstart_seq_ctrl #(
    parameter int CODE_W     = 8,
    parameter int DIV_W      = 8,
    parameter int PRECHG_CYC = 16,
    parameter int FAULT_HOLD = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en,
    input  logic              uvlo,
    input  logic              ocp,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic [CODE_W-1:0] target,
    output logic [CODE_W-1:0] ss_code,
    output logic              drv_en,
    output logic              ss_done,
    output logic              discharge,
    output logic              fault,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRECHG = 3'd1,
        S_RAMP   = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } st_t;

    localparam int HOLD_MAX =
        (PRECHG_CYC > FAULT_HOLD) ? PRECHG_CYC : FAULT_HOLD;
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRECHG_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(FAULT_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DIV_W-1:0]  DIV_MAX   = '1;
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;

    st_t cur;
    st_t nxt;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DIV_W-1:0]  presc;
    logic [DIV_W-1:0]  presc_nxt;
    logic [CODE_W-1:0] code_nxt;

    logic active;
    logic trip;
    logic stop;
    logic step;

    // Supply/substrate pins carry no logic; fold them into a sink.
    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB};

    assign state = cur;

    // Fault and enable-drop qualifiers for the powered states.
    always_comb begin
        active = (cur == S_PRECHG) ||
                 (cur == S_RAMP)   ||
                 (cur == S_DONE);
        trip   = active && (ocp || uvlo);
        stop   = active && !en;
        step   = (cur == S_RAMP) && (presc >= ramp_div);
    end

    // Next-state decode; fault beats enable-drop beats normal flow.
    always_comb begin
        nxt = cur;
        if (trip) begin
            nxt = S_FAULT;
        end else if (stop) begin
            nxt = S_IDLE;
        end else begin
            unique case (cur)
                S_IDLE: begin
                    if (en && !uvlo)
                        nxt = S_PRECHG;
                end
                S_PRECHG: begin
                    if (cnt >= PRE_LAST)
                        nxt = S_RAMP;
                end
                S_RAMP: begin
                    if (target <= ss_code)
                        nxt = S_DONE;
                end
                S_DONE: begin
                    if (target > ss_code)
                        nxt = S_RAMP;
                end
                S_FAULT: begin
                    if (cnt >= HOLD_LAST)
                        nxt = S_IDLE;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Dwell counter for precharge and fault hold-off, saturating.
    always_comb begin
        cnt_nxt = '0;
        if (!trip && !stop) begin
            if ((cur == S_PRECHG && cnt < PRE_LAST) ||
                (cur == S_FAULT && cnt < HOLD_LAST)) begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end
        end
    end

    // Ramp prescaler: counts 0..ramp_div while the code is climbing.
    always_comb begin
        presc_nxt = '0;
        if (!trip && !stop && cur == S_RAMP &&
            target > ss_code && !step) begin
            presc_nxt = (presc == DIV_MAX) ? presc : presc + 1'b1;
        end
    end

    // Reference code: zero when unpowered, clamps down to target.
    always_comb begin
        code_nxt = ss_code;
        if (trip || stop) begin
            code_nxt = '0;
        end else begin
            unique case (cur)
                S_IDLE:   code_nxt = '0;
                S_PRECHG: code_nxt = ss_code;
                S_RAMP: begin
                    if (target < ss_code)
                        code_nxt = target;
                    else if (target > ss_code && step &&
                             ss_code != CODE_MAX)
                        code_nxt = ss_code + 1'b1;
                end
                S_DONE: begin
                    if (target < ss_code)
                        code_nxt = target;
                end
                S_FAULT:  code_nxt = '0;
                default:  code_nxt = '0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    // Dwell counter and prescaler registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            presc <= '0;
        end else begin
            cnt   <= cnt_nxt;
            presc <= presc_nxt;
        end
    end

    // Soft-start DAC code register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ss_code <= '0;
        else
            ss_code <= code_nxt;
    end

    // Registered status/control outputs decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drv_en    <= 1'b0;
            ss_done   <= 1'b0;
            discharge <= 1'b1;
            fault     <= 1'b0;
        end else begin
            drv_en    <= (nxt == S_RAMP) || (nxt == S_DONE);
            ss_done   <= (nxt == S_DONE);
            discharge <= (nxt == S_IDLE) || (nxt == S_FAULT);
            fault     <= (nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_softstart_seq_ctrl.sv
// Bench for softstart_seq_ctrl: directed table, async reset,
// then random stimulus against a phase/countdown reference model.
module tb_softstart_seq_ctrl;

    localparam int PRECHG_CYC = 16;
    localparam int FAULT_HOLD = 64;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       CELV = 1'b1;
    logic       CELG = 1'b0;
    logic       SUB = 1'b0;
    logic       en = 1'b0;
    logic       uvlo = 1'b0;
    logic       ocp = 1'b0;
    logic [7:0] ramp_div = 8'd0;
    logic [7:0] target = 8'd0;
    logic [7:0] ss_code;
    logic       drv_en;
    logic       ss_done;
    logic       discharge;
    logic       fault;
    logic [2:0] state;

    int nvec = 0;
    int nmis = 0;

    // Reference model: phase number, clocks left in timed phase,
    // current code, clocks spent on the current code step.
    int m_ph;
    int m_left;
    int m_code;
    int m_since;

    typedef struct {
        bit en;
        bit uvlo;
        bit ocp;
        int dv;
        int tg;
        int n;
        int st;
        int code;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    softstart_seq_ctrl #(
        .CODE_W(8), .DIV_W(8),
        .PRECHG_CYC(PRECHG_CYC), .FAULT_HOLD(FAULT_HOLD)
    ) dut (
        .clk(clk), .rstn(rstn),
        .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .uvlo(uvlo), .ocp(ocp),
        .ramp_div(ramp_div), .target(target),
        .ss_code(ss_code), .drv_en(drv_en), .ss_done(ss_done),
        .discharge(discharge), .fault(fault), .state(state)
    );

    task automatic check(input string nm, input int st, input int code);
        bit e_drv;
        bit e_done;
        bit e_dis;
        bit e_flt;
        e_drv  = (st == 2) || (st == 3);
        e_done = (st == 3);
        e_dis  = (st == 0) || (st == 4);
        e_flt  = (st == 4);
        nvec++;
        if (state !== 3'(st) || ss_code !== 8'(code) ||
            drv_en !== e_drv || ss_done !== e_done ||
            discharge !== e_dis || fault !== e_flt) begin
            nmis++;
            $display("FAIL %s: got st=%0d code=%0d drv=%b done=%b dis=%b flt=%b want st=%0d code=%0d drv=%b done=%b dis=%b flt=%b",
                     nm, state, ss_code, drv_en, ss_done, discharge, fault,
                     st, code, e_drv, e_done, e_dis, e_flt);
        end
    endtask

    task automatic model_step(input bit e, input bit u, input bit o,
                              input int dv, input int tg);
        bit powered;
        powered = (m_ph == 1) || (m_ph == 2) || (m_ph == 3);
        if (powered && (o || u)) begin
            m_ph   = 4;
            m_left = FAULT_HOLD;
            m_code = 0;
        end else if (powered && !e) begin
            m_ph   = 0;
            m_code = 0;
        end else begin
            case (m_ph)
                0: if (e && !u) begin
                    m_ph   = 1;
                    m_left = PRECHG_CYC;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph    = 2;
                        m_since = 0;
                    end
                end
                2: begin
                    if (m_code >= tg) begin
                        m_code = tg;
                        m_ph   = 3;
                    end else begin
                        m_since++;
                        if (m_since >= dv + 1) begin
                            m_since = 0;
                            if (m_code < 255)
                                m_code++;
                        end
                    end
                end
                3: begin
                    if (tg < m_code) begin
                        m_code = tg;
                    end else if (tg > m_code) begin
                        m_ph    = 2;
                        m_since = 0;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0)
                        m_ph = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {en, uvlo, ocp, ramp_div, target, clocks, state, code}
        tbl.push_back('{1, 0, 0, 0,  10,   1, 1,   0});
        tbl.push_back('{1, 0, 0, 0,  10,  15, 1,   0});
        tbl.push_back('{1, 0, 0, 0,  10,   1, 2,   0});
        tbl.push_back('{1, 0, 0, 0,  10,  10, 2,  10});
        tbl.push_back('{1, 0, 0, 0,  10,   1, 3,  10});
        tbl.push_back('{0, 0, 0, 0,  10,   1, 0,   0});
        tbl.push_back('{1, 0, 0, 3,   4,  17, 2,   0});
        tbl.push_back('{1, 0, 0, 3,   4,   4, 2,   1});
        tbl.push_back('{1, 0, 0, 3,   4,  12, 2,   4});
        tbl.push_back('{1, 0, 0, 3,   4,   1, 3,   4});
        tbl.push_back('{1, 0, 0, 0, 200, 197, 2, 200});
        tbl.push_back('{1, 0, 0, 0, 200,   1, 3, 200});
        tbl.push_back('{1, 0, 0, 0, 100,   1, 3, 100});
        tbl.push_back('{1, 0, 0, 0, 150,   1, 2, 100});
        tbl.push_back('{1, 0, 0, 0, 150,  50, 2, 150});
        tbl.push_back('{1, 0, 0, 0, 150,   1, 3, 150});
        tbl.push_back('{0, 0, 0, 0,  20,   1, 0,   0});
        tbl.push_back('{1, 0, 0, 0,  20,  17, 2,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   5, 2,   5});
        tbl.push_back('{1, 0, 1, 0,  20,   1, 4,   0});
        tbl.push_back('{1, 0, 0, 0,  20,  63, 4,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   1, 0,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   1, 1,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   5, 1,   0});
        tbl.push_back('{0, 0, 0, 0,  20,   1, 0,   0});
        tbl.push_back('{1, 0, 0, 0,  20,  17, 2,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   3, 2,   3});
        tbl.push_back('{0, 0, 0, 0,  20,   1, 0,   0});
        tbl.push_back('{1, 1, 0, 0,  20,   5, 0,   0});
        tbl.push_back('{1, 0, 0, 0,  20,   1, 1,   0});
        tbl.push_back('{1, 1, 0, 0,  20,   1, 4,   0});
        tbl.push_back('{0, 0, 0, 0,  20,  64, 0,   0});
        tbl.push_back('{1, 0, 0, 0,   0,  17, 2,   0});
        tbl.push_back('{1, 0, 0, 0,   0,   1, 3,   0});

        #12;
        check("reset", 0, 0);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            en       = tbl[i].en;
            uvlo     = tbl[i].uvlo;
            ocp      = tbl[i].ocp;
            ramp_div = 8'(tbl[i].dv);
            target   = 8'(tbl[i].tg);
            repeat (tbl[i].n) tick();
            check($sformatf("row%0d", i), tbl[i].st, tbl[i].code);
        end

        // Asynchronous reset landing between edges mid-ramp.
        target = 8'd50;
        repeat (4) tick();
        check("ramp_before_rst", 2, 3);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", 0, 0);
        #3;
        rstn = 1'b1;

        m_ph    = 0;
        m_left  = 0;
        m_code  = 0;
        m_since = 0;

        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            model_step(en, uvlo, ocp, int'(ramp_div), int'(target));
            #1;
            check($sformatf("rand%0d", k), m_ph, m_code);
            if ($urandom_range(0, 199) == 0)
                en = 1'b0;
            else if ($urandom_range(0, 19) == 0)
                en = 1'b1;
            uvlo = ($urandom_range(0, 149) == 0);
            ocp  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    target = 8'd255;
                else
                    target = 8'($urandom_range(0, 40));
            end
            if (m_ph == 0 && $urandom_range(0, 9) == 0)
                ramp_div = 8'($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
